mux_n_sync: RTL and testbench

Parametrised N-channel, m-bit registered selector for the DDS output path. It replaces the static 2-input mux wherever a waveform source is changed at run time. Channel changes are requested over a valid/ready handshake and applied only on a sync strobe (phase-accumulator wrap or zero-cross), so the output never jumps mid-period. A timeout forces the switch if no sync arrives.

---
 rtl/mux_n_sync.sv | 181 ++++++++++++++++++
 tb/tb_mux_n_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_n_sync.sv
// mux_n_sync: N-channel, m-bit registered selector for the DDS output path.
//
// Channel changes arrive over a valid/ready handshake and take effect only on
// a sync strobe (accumulator wrap / zero-cross), so the output never jumps
// mid-period. If no sync arrives within TIMEOUT cycles the switch is forced.
//
// Optional feature: define MUX_N_SYNC_BLANK_EN to insert BLANK_CYC zero-output
// cycles after every switch; done/timeout then pulse at the end of the blank.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_bus     in   N*m   channel k at bits [k*m+m-1 : k*m]
//   sel_req    in   SELW  requested channel
//   req_valid  in   1     request strobe
//   req_ready  out  1     high while idle (request can be accepted)
//   sync       in   1     switch-permitted strobe
//   out        out  m     registered selected data
//   cur_sel    out  SELW  channel currently driving out
//   done       out  1     pulse when a switch (or same-channel request) completes
//   timeout    out  1     pulse with done when the switch was forced
//   err        out  1     pulse when a request names a channel >= N
//
// Parameter constraints: 2 <= N <= 16, 2**SELW >= N, TIMEOUT >= 1,
// BLANK_CYC >= 1 when blanking is compiled in.

module mux_n_sync #(
  parameter int unsigned m         = 12,
  parameter int unsigned N         = 4,
  parameter int unsigned SELW      = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*m-1:0]    in_bus,
  input  logic [SELW-1:0]   sel_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              sync,
  output logic [m-1:0]      out,
  output logic [SELW-1:0]   cur_sel,
  output logic              done,
  output logic              timeout,
  output logic              err
);

  // One counter serves both the sync timeout and the blanking interval.
  localparam int unsigned CntMax = (TIMEOUT > BLANK_CYC) ? TIMEOUT : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [SELW:0] NumCh = (SELW + 1)'(N);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1
`ifdef MUX_N_SYNC_BLANK_EN
    ,
    StBlank = 2'd2
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0]   pending_q, pending_d;
  logic [SELW-1:0]   cur_sel_q, cur_sel_d;
  logic [m-1:0]      out_q, out_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
`ifdef MUX_N_SYNC_BLANK_EN
  // Remembers a forced switch until done is reported at the end of the blank.
  logic              forced_q, forced_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= '0;
      cur_sel_q <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef MUX_N_SYNC_BLANK_EN
      forced_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cur_sel_q <= cur_sel_d;
      out_q     <= out_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
`ifdef MUX_N_SYNC_BLANK_EN
      forced_q  <= forced_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    cur_sel_d = cur_sel_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = 1'b0;
`ifdef MUX_N_SYNC_BLANK_EN
    forced_d  = forced_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if ({1'b0, sel_req} >= NumCh) begin
            err_d = 1'b1;
          end else if (sel_req == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            pending_d = sel_req;
            cnt_d     = '0;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        // A sync on the timeout edge wins, so timeout is only flagged without sync.
        if (sync || (cnt_q == CntW'(TIMEOUT - 1))) begin
          cur_sel_d = pending_q;
          cnt_d     = '0;
`ifdef MUX_N_SYNC_BLANK_EN
          forced_d  = !sync;
          state_d   = StBlank;
`else
          done_d    = 1'b1;
          timeout_d = !sync;
          state_d   = StIdle;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef MUX_N_SYNC_BLANK_EN
      StBlank: begin
        if (cnt_q == CntW'(BLANK_CYC - 1)) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          timeout_d = forced_q;
          forced_d  = 1'b0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = (state_q == StIdle);
    out_d     = in_bus[int'(cur_sel_q) * m +: m];
`ifdef MUX_N_SYNC_BLANK_EN
    if (state_q == StBlank) begin
      out_d = '0;
    end
`endif
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mux_n_sync.sv
// Self-checking bench for mux_n_sync. Expected outputs come from a timeline
// model: a request for a new channel switches at min(first sync edge, TIMEOUT
// edges) after acceptance, with optional blanking afterwards.
module tb_mux_n_sync;

  localparam int unsigned M   = 12;
  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 3;
  localparam int unsigned TO  = 8;
  localparam int unsigned BC  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*M-1:0]  in_bus;
  logic [SW-1:0]     sel_req;
  logic              req_valid;
  logic              req_ready;
  logic              sync;
  logic [M-1:0]      dout;
  logic [SW-1:0]     cur_sel;
  logic              done;
  logic              tmo;
  logic              err;

  int    checks   = 0;
  int    failures = 0;
  int    mcur     = 0;   // model's current channel
  bit    rnd_bus  = 1'b0;
  string phase    = "init";

  always #5 clk = ~clk;

  mux_n_sync #(
    .m        (M),
    .N        (NCH),
    .SELW     (SW),
    .TIMEOUT  (TO),
    .BLANK_CYC(BC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bus   (in_bus),
    .sel_req  (sel_req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .sync     (sync),
    .out      (dout),
    .cur_sel  (cur_sel),
    .done     (done),
    .timeout  (tmo),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    end
  endtask

  task automatic new_bus();
    if (rnd_bus) begin
      for (int k = 0; k < int'(NCH); k++) in_bus[k*M +: M] = M'($urandom);
    end
  endtask

  // One clock edge; expected out is the slice selected before the edge.
  task automatic cycle(input bit e_done, input bit e_to, input bit e_err, input bit e_rdy,
                       input bit e_blank, input int new_cur);
    logic [M-1:0] e_out;
    e_out = e_blank ? '0 : in_bus[mcur*M +: M];
    @(posedge clk);
    #1;
    mcur = new_cur;
    chk("out",       32'(dout),      32'(e_out));
    chk("cur_sel",   32'(cur_sel),   32'(mcur));
    chk("done",      32'(done),      32'(e_done));
    chk("timeout",   32'(tmo),       32'(e_to));
    chk("err",       32'(err),       32'(e_err));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    new_bus();
  endtask

  task automatic do_reset(input int ncyc);
    rst       = 1'b1;
    req_valid = 1'b0;
    sync      = 1'b0;
    repeat (ncyc) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    rst = 1'b0;
  endtask

  // Request channel s; d = edge after acceptance carrying sync (0: none).
  task automatic do_req(input int s, input int d);
    bit synced;
    int sw;
    req_valid = 1'b1;
    sel_req   = SW'(s);
    sync      = 1'($urandom);  // sync on the acceptance edge must be ignored
    if (s >= int'(NCH)) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mcur);
    end else if (s == mcur) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mcur);
    end else begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mcur);
      synced = (d >= 1) && (d <= int'(TO));
      sw     = synced ? d : int'(TO);
      for (int k = 1; k <= sw; k++) begin
        sync      = (k == d);
        req_valid = 1'($urandom);
        sel_req   = SW'($urandom);
        if (k < sw) begin
          cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mcur);
        end else begin
`ifdef MUX_N_SYNC_BLANK_EN
          cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
          for (int b = 1; b <= int'(BC); b++) begin
            sync      = 1'($urandom);
            req_valid = 1'b1;
            sel_req   = SW'((s + 1) % int'(NCH));
            cycle(b == int'(BC), !synced && (b == int'(BC)), 1'b0, b == int'(BC), 1'b1, s);
          end
`else
          cycle(1'b1, !synced, 1'b0, 1'b1, 1'b0, s);
`endif
        end
      end
    end
    req_valid = 1'b0;
    sync      = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mcur);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    sync      = 1'b0;
    sel_req   = '0;
    in_bus    = '0;
    in_bus[0 +: M] = 12'h123;

    phase = "reset";
    do_reset(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    in_bus = {12'h444, 12'h333, 12'h222, 12'h111};
    phase = "synced";     do_req(2, 5);
    phase = "timeout";    do_req(3, 0);
    phase = "invalid";    do_req(4, 0);
    phase = "invalid7";   do_req(7, 0);
    phase = "same";       do_req(3, 0);
    phase = "sync_at_to"; do_req(0, int'(TO));
    phase = "earliest";   do_req(1, 1);

    phase = "rst_mid";
    do_reset(1);
    req_valid = 1'b1;
    sel_req   = SW'(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    req_valid = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    rst  = 1'b0;
    sync = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    sync = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    phase   = "random";
    rnd_bus = 1'b1;
    new_bus();
    repeat (60) begin
      do_req(int'($urandom_range(0, 7)), int'($urandom_range(0, TO + 2)));
      if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mcur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
